// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg (package)
//  Description : Shared definitions for the instruction fetch stage: the
//                fetch state encoding and the default halt opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states. S_HALT is only reachable in builds with
  // FETCH_HALT_EN defined.
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bundle of the fetch stage's memory, redirect and decode
//                signals.
//    pc            fetch -> memory   fetch address
//    mem_instr     memory -> fetch   registered ram[pc] from previous edge
//    branch_taken  execute -> fetch  redirect request
//    branch_target execute -> fetch  redirect address
//    instr_ready   decode -> fetch   decode accepts current word
//    instr_valid   fetch -> decode   instr/instr_pc are live
//    instr         fetch -> decode   instruction word
//    instr_pc      fetch -> decode   address of instr
//    halted        fetch -> system   fetch stopped on halt word
//  Modports    : master = fetch stage, slave = surrounding system
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int WIDTH   = 16,
  parameter int PC_BITS = 4
) ();

  logic [PC_BITS-1:0] pc;
  logic [WIDTH-1:0]   mem_instr;
  logic               branch_taken;
  logic [PC_BITS-1:0] branch_target;
  logic               instr_ready;
  logic               instr_valid;
  logic [WIDTH-1:0]   instr;
  logic [PC_BITS-1:0] instr_pc;
  logic               halted;

  modport master (
    output pc, instr_valid, instr, instr_pc, halted,
    input  mem_instr, branch_taken, branch_target, instr_ready
  );

  modport slave (
    input  pc, instr_valid, instr, instr_pc, halted,
    output mem_instr, branch_taken, branch_target, instr_ready
  );

endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Single-stage instruction fetch in front of a memory with a
//                registered read port. Streams sequential words to decode,
//                holds a word stable while decode stalls, and redirects on
//                branch_taken with exactly one bubble cycle.
//  Ports       : clk      - clock, all state on rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - instr_fetch_if.master (memory/redirect/decode)
//  Parameters  : WIDTH, PC_BITS, HALT_WORD
//  Options     : FETCH_HALT_EN - when defined, accepting HALT_WORD stops
//                fetch until reset and raises halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                WIDTH     = 16,
  parameter int                PC_BITS   = 4,
  parameter logic [WIDTH-1:0]  HALT_WORD = WIDTH'(HALT_WORD_DEFAULT)
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  instr_fetch_if.master bus
);

  fetch_state_t       r_state,     w_state_nxt;
  logic [PC_BITS-1:0] r_pc,        w_pc_nxt;
  logic [PC_BITS-1:0] r_req_pc;
  logic               r_req_valid, w_req_valid_nxt;
  logic [WIDTH-1:0]   r_hold_instr, w_hold_instr_nxt;
  logic [PC_BITS-1:0] r_hold_pc,    w_hold_pc_nxt;

  logic [WIDTH-1:0]   w_instr;
  logic [PC_BITS-1:0] w_instr_pc;
  logic               w_instr_valid;
  logic               w_accept;
  logic               w_halt_hit;
  logic [PC_BITS-1:0] w_pc_inc;

  // Natural wrap from all-ones back to zero.
  assign w_pc_inc = r_pc + PC_BITS'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RUN;
      r_pc         <= '0;
      r_req_pc     <= '0;
      r_req_valid  <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      // The memory samples pc on the same edge, so req_pc always names the
      // word that will appear on mem_instr.
      r_req_pc     <= r_pc;
      r_req_valid  <= w_req_valid_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output selection: live memory word in RUN, hold register in STALL
  // --------------------------------------------------------------------------
  always_comb begin
    w_instr       = bus.mem_instr;
    w_instr_pc    = r_req_pc;
    w_instr_valid = r_req_valid;
    case (r_state)
      S_STALL: begin
        w_instr       = r_hold_instr;
        w_instr_pc    = r_hold_pc;
        w_instr_valid = 1'b1;
      end
      S_HALT: begin
        w_instr_valid = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_accept = w_instr_valid & bus.instr_ready;

`ifdef FETCH_HALT_EN
  assign w_halt_hit = w_accept && (w_instr == HALT_WORD);
`else
  assign w_halt_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state / next-pc logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_valid_nxt  = r_req_valid;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;

    case (r_state)
      S_RUN, S_STALL: begin
        if (bus.branch_taken) begin
          // Redirect beats everything; the word already in flight from the
          // old stream is squashed, giving the single bubble cycle.
          w_state_nxt      = S_RUN;
          w_pc_nxt         = bus.branch_target;
          w_req_valid_nxt  = 1'b0;
          w_hold_instr_nxt = '0;
          w_hold_pc_nxt    = '0;
        end else if (w_halt_hit) begin
          w_state_nxt     = S_HALT;
          w_req_valid_nxt = 1'b0;
        end else if (r_state == S_RUN) begin
          if (!w_instr_valid || bus.instr_ready) begin
            w_pc_nxt        = w_pc_inc;
            w_req_valid_nxt = 1'b1;
          end else begin
            // Decode refused the word: park it and freeze pc so that
            // mem_instr keeps showing ram[pc], the next word in order.
            w_state_nxt      = S_STALL;
            w_hold_instr_nxt = w_instr;
            w_hold_pc_nxt    = w_instr_pc;
            w_req_valid_nxt  = 1'b1;
          end
        end else begin
          w_req_valid_nxt = 1'b1;
          if (bus.instr_ready) begin
            // mem_instr already carries ram[pc], so RUN resumes with no bubble.
            w_state_nxt = S_RUN;
            w_pc_nxt    = w_pc_inc;
          end
        end
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        w_req_valid_nxt = 1'b0;
      end
`endif
      default: begin
        w_state_nxt     = S_RUN;
        w_req_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.pc          = r_pc;
  assign bus.instr       = w_instr;
  assign bus.instr_pc    = w_instr_pc;
  assign bus.instr_valid = w_instr_valid;

`ifdef FETCH_HALT_EN
  assign bus.halted = (r_state == S_HALT);
`else
  // Constant zero; HALT_WORD has no effect in this build.
  assign bus.halted = 1'b0 & (w_instr == HALT_WORD);
`endif

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A driver issues
//                per-cycle ready/branch stimulus and pushes the expected
//                outputs from a program-order reference model into a
//                scoreboard queue; a monitor pops and compares.
//  Options     : FETCH_HALT_EN - also runs the halt scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic clk;
  logic reset_n;

  instr_fetch_if #(.WIDTH(16), .PC_BITS(4)) bus ();

  instr_fetch #(.WIDTH(16), .PC_BITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with a registered read port.
  logic [15:0] ram [16];
  always @(posedge clk) bus.mem_instr <= ram[bus.pc];

  typedef struct {
    logic        v;
    logic        h;
    logic [3:0]  a;
    logic [3:0]  p;
    logic [15:0] w;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model: address of the next word in program order.
  logic [3:0] m_addr;
  logic       m_bubble;
  logic       m_halted;
  logic [3:0] m_hpc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // Called at a negedge: drive this cycle's inputs, record what the DUT
  // must show now, advance the model, then move to the next negedge.
  task automatic cycle(input bit rdy, input bit br, input logic [3:0] tgt);
    exp_t e;
    bus.instr_ready   = rdy;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    e.h = m_halted;
    e.v = !m_bubble && !m_halted;
    e.a = m_addr;
    e.w = ram[m_addr];
    e.p = m_halted ? m_hpc : (m_bubble ? m_addr : m_addr + 4'd1);
    sb.push_back(e);
    if (!m_halted) begin
      if (br) begin
        m_addr   = tgt;
        m_bubble = 1'b1;
      end else if (e.v && rdy) begin
`ifdef FETCH_HALT_EN
        if (e.w == HALT) begin
          m_halted = 1'b1;
          m_hpc    = m_addr + 4'd1;
        end else begin
          m_addr = m_addr + 4'd1;
        end
`else
        m_addr = m_addr + 4'd1;
`endif
      end else begin
        m_bubble = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset(input bit reload);
    reset_n          = 1'b0;
    bus.instr_ready  = 1'b1;
    bus.branch_taken = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    if (reload) begin
      for (int i = 0; i < 16; i++) ram[i] = 16'($urandom_range(0, 16'hFFFE));
    end
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    m_addr   = 4'd0;
    m_bubble = 1'b1;
    m_halted = 1'b0;
    m_hpc    = 4'd0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid", 32'(bus.instr_valid), 32'(e.v));
        chk("halted", 32'(bus.halted), 32'(e.h));
        chk("pc", 32'(bus.pc), 32'(e.p));
        if (e.v) begin
          chk("instr_pc", 32'(bus.instr_pc), 32'(e.a));
          chk("instr", 32'(bus.instr), 32'(e.w));
        end
      end
    end
  end

  // Driver
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 16'hA000 + 16'(i);
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 4'd0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);

    // Sequential stream 0..3 with decode always ready.
    do_reset(1'b0);
    repeat (5) cycle(1'b1, 1'b0, 4'd0);

    // Stall three cycles while word 1 is presented, then resume.
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
    repeat (3) cycle(1'b0, 1'b0, 4'd0);
    repeat (3) cycle(1'b1, 1'b0, 4'd0);

    // Branch to 9 while word 2 is presented.
    do_reset(1'b0);
    repeat (3) cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 4'd9);
    repeat (3) cycle(1'b1, 1'b0, 4'd0);

    // Wrap from 14 through 15 to 0,1.
    cycle(1'b1, 1'b1, 4'd14);
    repeat (5) cycle(1'b1, 1'b0, 4'd0);

    // Branch during a stall.
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 4'd5);
    repeat (3) cycle(1'b1, 1'b0, 4'd0);

    // Reset asserted mid-stall, then restart from address 0.
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
    repeat (2) cycle(1'b0, 1'b0, 4'd0);
    do_reset(1'b0);
    repeat (4) cycle(1'b1, 1'b0, 4'd0);

    // Randomised traffic over a few random memory images.
    for (int r = 0; r < 3; r++) begin
      do_reset(1'b1);
      for (int n = 0; n < 200; n++) begin
        cycle(($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0),
              4'($urandom_range(0, 15)));
      end
    end

`ifdef FETCH_HALT_EN
    // Halt word at address 2: fetch stops and ignores redirects until reset.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) ram[i] = 16'hA000 + 16'(i);
    ram[2] = HALT;
    repeat (4) cycle(1'b1, 1'b0, 4'd0);
    for (int n = 0; n < 10; n++) cycle(1'b1, n[0], 4'd7);
    do_reset(1'b0);
    repeat (3) cycle(1'b1, 1'b0, 4'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
